// File: rtl/fbs_pkg.sv
// rtl/fbs_pkg.sv - shared types and helpers for the triple-buffer frame bank scheduler
package fbs_pkg;

  typedef logic [1:0] bank_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_FILL = 2'd2,
    S_RUN  = 2'd3
  } fbs_state_e;

  localparam logic [1:0] ST_IDLE = S_IDLE;
  localparam logic [1:0] ST_ARM  = S_ARM;
  localparam logic [1:0] ST_FILL = S_FILL;
  localparam logic [1:0] ST_RUN  = S_RUN;

  // With banks 0..2 and a != b, the remaining bank is 3 - a - b.
  function automatic bank_t third_bank(input bank_t a, input bank_t b);
    return 2'd3 - a - b;
  endfunction

endpackage

// File: rtl/frame_bank_scheduler_if.sv
// rtl/frame_bank_scheduler_if.sv - frame marker inputs and SDRAM window outputs of the scheduler
// FBS_STATS_EN adds the DROP_CNT / FRAME_CNT statistics signals.
interface frame_bank_scheduler_if #(
  parameter int ADDR_W = 22
);
  import fbs_pkg::*;

  logic              ENABLE;
  logic              WR_VSYNC;
  logic              RD_VSYNC;
  logic [ADDR_W-1:0] WR_ADDR;
  logic [ADDR_W-1:0] WR_MAX_ADDR;
  logic [ADDR_W-1:0] RD_ADDR;
  logic [ADDR_W-1:0] RD_MAX_ADDR;
  logic              WR_LOAD;
  logic              RD_LOAD;
  bank_t             WR_BANK;
  bank_t             RD_BANK;
  logic              RD_FRAME_VALID;
`ifdef FBS_STATS_EN
  logic [15:0]       DROP_CNT;
  logic [15:0]       FRAME_CNT;
`endif

  modport master (
    input  ENABLE, WR_VSYNC, RD_VSYNC,
    output WR_ADDR, WR_MAX_ADDR, RD_ADDR, RD_MAX_ADDR,
    output WR_LOAD, RD_LOAD, WR_BANK, RD_BANK, RD_FRAME_VALID
`ifdef FBS_STATS_EN
    , output DROP_CNT, FRAME_CNT
`endif
  );

  modport slave (
    output ENABLE, WR_VSYNC, RD_VSYNC,
    input  WR_ADDR, WR_MAX_ADDR, RD_ADDR, RD_MAX_ADDR,
    input  WR_LOAD, RD_LOAD, WR_BANK, RD_BANK, RD_FRAME_VALID
`ifdef FBS_STATS_EN
    , input DROP_CNT, FRAME_CNT
`endif
  );

endinterface

// File: rtl/fbs_evt_sync.sv
// rtl/fbs_evt_sync.sv - 2-flop synchronizer plus registered rising-edge detector
// The event pulse is one cycle wide and appears three clocks after the input edge.
module fbs_evt_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic async_i,
  output logic evt_o
);

  logic [1:0] sync_q;
  logic       prev_q;
  logic       evt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
      evt_q  <= 1'b0;
    end else if (clr_i) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
      evt_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], async_i};
      prev_q <= sync_q[1];
      evt_q  <= sync_q[1] & ~prev_q;
    end
  end

  assign evt_o = evt_q;

endmodule

// File: rtl/frame_bank_scheduler.sv
// rtl/frame_bank_scheduler.sv - triple-buffer bank rotation between a frame writer and reader
// Optional FBS_STATS_EN adds saturating drop and wrapping completed-frame counters.
module frame_bank_scheduler
  import fbs_pkg::*;
#(
  parameter int ADDR_W      = 22,
  parameter int BASE_ADDR   = 0,
  parameter int FRAME_WORDS = 384000,
  parameter int LOAD_CYCLES = 4
) (
  input logic                    CTRL_CLK,
  input logic                    RESET_N,
  frame_bank_scheduler_if.master bus
);

  if (LOAD_CYCLES < 1 || LOAD_CYCLES > 15) begin : g_bad_load
    $error("LOAD_CYCLES must be in 1..15");
  end
  if (longint'(BASE_ADDR) + 3 * longint'(FRAME_WORDS) > (longint'(1) << ADDR_W)) begin : g_bad_win
    $error("three frame banks do not fit in ADDR_W bits");
  end

  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] FW_A   = ADDR_W'(FRAME_WORDS);
  localparam logic [3:0]        LOAD_N = 4'(LOAD_CYCLES);

  function automatic logic [ADDR_W-1:0] win_start(input bank_t b);
    return BASE_A + ADDR_W'(b) * FW_A;
  endfunction

  logic wr_evt, rd_evt, clr;
  assign clr = ~bus.ENABLE;

  fbs_evt_sync u_wr_sync (.clk_i(CTRL_CLK), .rst_ni(RESET_N), .clr_i(clr), .async_i(bus.WR_VSYNC), .evt_o(wr_evt));
  fbs_evt_sync u_rd_sync (.clk_i(CTRL_CLK), .rst_ni(RESET_N), .clr_i(clr), .async_i(bus.RD_VSYNC), .evt_o(rd_evt));

  logic [1:0] state_q, state_d;
  bank_t      wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d, ready_bank_q, ready_bank_d;
  logic       ready_valid_q, ready_valid_d, frame_valid_q, frame_valid_d;
  logic       wr_start, rd_start;
  logic [3:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_max_q, rd_addr_q, rd_max_q;

  always_comb begin
    state_d       = state_q;
    wr_bank_d     = wr_bank_q;
    rd_bank_d     = rd_bank_q;
    ready_bank_d  = ready_bank_q;
    ready_valid_d = ready_valid_q;
    frame_valid_d = frame_valid_q;
    wr_start      = 1'b0;
    rd_start      = 1'b0;
    if (!bus.ENABLE) begin
      state_d       = ST_IDLE;
      wr_bank_d     = 2'd0;
      rd_bank_d     = 2'd1;
      ready_bank_d  = 2'd0;
      ready_valid_d = 1'b0;
      frame_valid_d = 1'b0;
    end else if (state_q == ST_IDLE) begin
      state_d = ST_ARM;
    end else begin
      if (wr_evt) begin
        wr_start = 1'b1;
        if (state_q == ST_ARM) begin
          state_d = ST_FILL;
        end else begin
          state_d       = ST_RUN;
          ready_bank_d  = wr_bank_q;
          ready_valid_d = 1'b1;
          wr_bank_d     = third_bank(rd_bank_q, wr_bank_q);
        end
      end
      // The read sees the write update of the same cycle, so it can take a just-finished frame.
      if (rd_evt) begin
        rd_start = 1'b1;
        if (ready_valid_d) begin
          rd_bank_d     = ready_bank_d;
          ready_valid_d = 1'b0;
          frame_valid_d = 1'b1;
        end
      end
    end
  end

  always_comb begin
    wr_cnt_d = 4'd0;
    rd_cnt_d = 4'd0;
    if (bus.ENABLE) begin
      wr_cnt_d = wr_start ? LOAD_N : (wr_cnt_q != 4'd0 ? wr_cnt_q - 4'd1 : 4'd0);
      rd_cnt_d = rd_start ? LOAD_N : (rd_cnt_q != 4'd0 ? rd_cnt_q - 4'd1 : 4'd0);
    end
  end

  always_ff @(posedge CTRL_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q       <= ST_IDLE;
      wr_bank_q     <= 2'd0;
      rd_bank_q     <= 2'd1;
      ready_bank_q  <= 2'd0;
      ready_valid_q <= 1'b0;
      frame_valid_q <= 1'b0;
      wr_cnt_q      <= 4'd0;
      rd_cnt_q      <= 4'd0;
      wr_addr_q     <= win_start(2'd0);
      wr_max_q      <= win_start(2'd0) + FW_A;
      rd_addr_q     <= win_start(2'd1);
      rd_max_q      <= win_start(2'd1) + FW_A;
    end else begin
      state_q       <= state_d;
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      ready_bank_q  <= ready_bank_d;
      ready_valid_q <= ready_valid_d;
      frame_valid_q <= frame_valid_d;
      wr_cnt_q      <= wr_cnt_d;
      rd_cnt_q      <= rd_cnt_d;
      wr_addr_q     <= win_start(wr_bank_d);
      wr_max_q      <= win_start(wr_bank_d) + FW_A;
      rd_addr_q     <= win_start(rd_bank_d);
      rd_max_q      <= win_start(rd_bank_d) + FW_A;
    end
  end

  assign bus.WR_ADDR        = wr_addr_q;
  assign bus.WR_MAX_ADDR    = wr_max_q;
  assign bus.RD_ADDR        = rd_addr_q;
  assign bus.RD_MAX_ADDR    = rd_max_q;
  assign bus.WR_LOAD        = (wr_cnt_q != 4'd0);
  assign bus.RD_LOAD        = (rd_cnt_q != 4'd0);
  assign bus.WR_BANK        = wr_bank_q;
  assign bus.RD_BANK        = rd_bank_q;
  assign bus.RD_FRAME_VALID = frame_valid_q;

`ifdef FBS_STATS_EN
  logic        arm_entry, frame_done, frame_drop;
  logic [15:0] drop_cnt_q, frame_cnt_q;

  assign arm_entry  = bus.ENABLE && (state_q == ST_IDLE);
  assign frame_done = bus.ENABLE && wr_evt && (state_q == ST_FILL || state_q == ST_RUN);
  assign frame_drop = frame_done && ready_valid_q;

  always_ff @(posedge CTRL_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      drop_cnt_q  <= 16'd0;
      frame_cnt_q <= 16'd0;
    end else if (arm_entry) begin
      drop_cnt_q  <= 16'd0;
      frame_cnt_q <= 16'd0;
    end else begin
      if (frame_drop && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
      if (frame_done) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign bus.DROP_CNT  = drop_cnt_q;
  assign bus.FRAME_CNT = frame_cnt_q;
`endif

endmodule

// File: tb/tb_frame_bank_scheduler.sv
// tb/tb_frame_bank_scheduler.sv - directed and randomized checks of frame_bank_scheduler against a frame-queue model
module tb_frame_bank_scheduler;

  localparam int ADDR_W      = 22;
  localparam int BASE_ADDR   = 0;
  localparam int FRAME_WORDS = 384000;
  localparam int LOAD_CYCLES = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  frame_bank_scheduler_if #(.ADDR_W(ADDR_W)) bus ();

  frame_bank_scheduler #(
    .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR), .FRAME_WORDS(FRAME_WORDS), .LOAD_CYCLES(LOAD_CYCLES)
  ) dut (
    .CTRL_CLK(clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: writer/reader bank, a queue of at most one finished frame, session phase.
  int m_phase;
  int m_wr, m_rd;
  int m_fv;
  int m_ready[$];
  int m_drops, m_frames;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_phase = 0; m_wr = 0; m_rd = 1; m_fv = 0;
    m_ready.delete();
  endtask

  task automatic m_arm();
    m_phase = 1; m_drops = 0; m_frames = 0;
  endtask

  task automatic m_event(input bit w, input bit r);
    int nb;
    if (w) begin
      if (m_phase == 1) begin
        m_phase = 2;
      end else begin
        if (m_ready.size() > 0) begin
          void'(m_ready.pop_front());
          m_drops++;
        end
        m_ready.push_back(m_wr);
        m_frames++;
        nb = 0;
        for (int b = 0; b < 3; b++) if (b != m_wr && b != m_rd) nb = b;
        m_wr = nb;
        m_phase = 3;
      end
    end
    if (r && m_ready.size() > 0) begin
      m_rd = m_ready.pop_front();
      m_fv = 1;
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, " wr_bank"}, 32'(bus.WR_BANK), m_wr);
    chk({tag, " rd_bank"}, 32'(bus.RD_BANK), m_rd);
    chk({tag, " wr_addr"}, 32'(bus.WR_ADDR), BASE_ADDR + m_wr * FRAME_WORDS);
    chk({tag, " wr_max"}, 32'(bus.WR_MAX_ADDR), BASE_ADDR + (m_wr + 1) * FRAME_WORDS);
    chk({tag, " rd_addr"}, 32'(bus.RD_ADDR), BASE_ADDR + m_rd * FRAME_WORDS);
    chk({tag, " rd_max"}, 32'(bus.RD_MAX_ADDR), BASE_ADDR + (m_rd + 1) * FRAME_WORDS);
    chk({tag, " frame_valid"}, 32'(bus.RD_FRAME_VALID), m_fv);
    chk({tag, " banks_differ"}, 32'(bus.WR_BANK != bus.RD_BANK), 1);
`ifdef FBS_STATS_EN
    chk({tag, " drop_cnt"}, 32'(bus.DROP_CNT), (m_drops > 65535) ? 65535 : m_drops);
    chk({tag, " frame_cnt"}, 32'(bus.FRAME_CNT), m_frames % 65536);
`endif
  endtask

  // Raise the requested markers, check nothing moves before the 4th clock, then the update and LOAD widths.
  task automatic edge_event(input bit w, input bit r, input string tag);
    @(negedge clk);
    if (w) bus.WR_VSYNC = 1'b1;
    if (r) bus.RD_VSYNC = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk({tag, " pre wr_load"}, 32'(bus.WR_LOAD), 0);
    chk({tag, " pre rd_load"}, 32'(bus.RD_LOAD), 0);
    check_state({tag, " pre"});
    @(posedge clk);
    #1;
    m_event(w, r);
    chk({tag, " wr_load"}, 32'(bus.WR_LOAD), 32'(w));
    chk({tag, " rd_load"}, 32'(bus.RD_LOAD), 32'(r));
    check_state(tag);
    @(negedge clk);
    bus.WR_VSYNC = 1'b0;
    bus.RD_VSYNC = 1'b0;
    for (int k = 1; k <= LOAD_CYCLES; k++) begin
      @(posedge clk);
      #1;
      chk({tag, " wr_load width"}, 32'(bus.WR_LOAD), (k < LOAD_CYCLES) ? 32'(w) : 0);
      chk({tag, " rd_load width"}, 32'(bus.RD_LOAD), (k < LOAD_CYCLES) ? 32'(r) : 0);
    end
  endtask

  task automatic restart_session(input string tag);
    @(negedge clk);
    bus.ENABLE = 1'b0;
    @(posedge clk);
    #1;
    m_reset();
    check_state({tag, " idle"});
    chk({tag, " idle wr_load"}, 32'(bus.WR_LOAD), 0);
    chk({tag, " idle rd_load"}, 32'(bus.RD_LOAD), 0);
    @(negedge clk);
    bus.ENABLE = 1'b1;
    @(posedge clk);
    #1;
    m_arm();
  endtask

  initial begin
    bit w, r;
    rst_n        = 1'b0;
    bus.ENABLE   = 1'b0;
    bus.WR_VSYNC = 1'b0;
    bus.RD_VSYNC = 1'b0;
    m_reset();
    m_drops = 0; m_frames = 0;
    repeat (3) @(posedge clk);
    #1;
    check_state("reset");
    chk("reset wr_load", 32'(bus.WR_LOAD), 0);
    chk("reset rd_load", 32'(bus.RD_LOAD), 0);

    @(negedge clk);
    rst_n      = 1'b1;
    bus.ENABLE = 1'b1;
    @(posedge clk);
    #1;
    m_arm();
    chk("release wr_load", 32'(bus.WR_LOAD), 0);

    edge_event(1'b1, 1'b0, "arm_wr");
    chk("arm_wr wr_bank const", 32'(bus.WR_BANK), 0);
    edge_event(1'b1, 1'b0, "fill_wr");
    chk("fill_wr wr_bank const", 32'(bus.WR_BANK), 2);
    edge_event(1'b0, 1'b1, "run_rd");
    chk("run_rd rd_bank const", 32'(bus.RD_BANK), 0);
    chk("run_rd wr_addr const", 32'(bus.WR_ADDR), 768000);
    chk("run_rd rd_max const", 32'(bus.RD_MAX_ADDR), 384000);
    chk("run_rd frame_valid const", 32'(bus.RD_FRAME_VALID), 1);

    restart_session("s2");
    edge_event(1'b1, 1'b0, "three_wr a");
    edge_event(1'b1, 1'b0, "three_wr b");
    edge_event(1'b1, 1'b0, "three_wr c");
    chk("three_wr wr_bank const", 32'(bus.WR_BANK), 0);
    chk("three_wr drops", 32'(m_drops), 1);
    edge_event(1'b1, 1'b1, "same_cycle");
    chk("same_cycle rd_bank const", 32'(bus.RD_BANK), 0);
    chk("same_cycle ready_empty", 32'(m_ready.size()), 0);

    // Drop ENABLE while a write LOAD pulse is active.
    @(negedge clk);
    bus.WR_VSYNC = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_load wr_load", 32'(bus.WR_LOAD), 1);
    @(negedge clk);
    bus.ENABLE   = 1'b0;
    bus.WR_VSYNC = 1'b0;
    @(posedge clk);
    #1;
    m_reset();
    check_state("disable");
    chk("disable wr_load", 32'(bus.WR_LOAD), 0);
    chk("disable rd_load", 32'(bus.RD_LOAD), 0);
    @(negedge clk);
    bus.ENABLE = 1'b1;
    @(posedge clk);
    #1;
    m_arm();
    edge_event(1'b0, 1'b1, "rearm_rd");
    edge_event(1'b1, 1'b0, "rearm_wr");
    edge_event(1'b1, 1'b0, "rearm_fill");

    restart_session("rand");
    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      if (!w && !r) w = 1'b1;
      edge_event(w, r, $sformatf("rand%0d", i));
    end

    // Asynchronous reset part-way through a frame, away from any clock edge.
    @(negedge clk);
    bus.WR_VSYNC = 1'b1;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    m_reset();
    check_state("async_rst");
    chk("async_rst wr_load", 32'(bus.WR_LOAD), 0);
    chk("async_rst rd_load", 32'(bus.RD_LOAD), 0);
    bus.WR_VSYNC = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      chk("post_rst wr_load", 32'(bus.WR_LOAD), 0);
      chk("post_rst rd_load", 32'(bus.RD_LOAD), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_bank_scheduler.md
FRAME_BANK_SCHEDULER -- requirements
Module: frame_bank_scheduler

Interface
REQ-001 Parameter ADDR_W, default 22: width of every SDRAM word address.
REQ-002 Parameter BASE_ADDR, default 0: word address of bank 0.
REQ-003 Parameter FRAME_WORDS, default 384000: words per frame bank (800x480).
REQ-004 Parameter LOAD_CYCLES, default 4: LOAD pulse width in CTRL_CLK cycles, legal range 1..15.
REQ-005 CTRL_CLK  in  1  sole clock; the block has one clock, and reset is asynchronous and active-low.
REQ-006 RESET_N  in  1  asynchronous active-low reset.
REQ-007 ENABLE  in  1  level, synchronous to CTRL_CLK; low holds the block idle.
REQ-008 WR_VSYNC  in  1  writer frame marker, asynchronous; rising edge = frame boundary.
REQ-009 RD_VSYNC  in  1  reader frame marker, asynchronous; rising edge = frame boundary.
REQ-010 WR_ADDR / WR_MAX_ADDR  out  ADDR_W each  write window start / end for the SDRAM write port.
REQ-011 RD_ADDR / RD_MAX_ADDR  out  ADDR_W each  read window start / end for the SDRAM read port.
REQ-012 WR_LOAD / RD_LOAD  out  1 each  port register-load and FIFO-clear pulses.
REQ-013 WR_BANK / RD_BANK  out  2 each  current bank index, 0..2.
REQ-014 RD_FRAME_VALID  out  1  reader is displaying a completed frame.

Function
REQ-015 Each VSYNC passes through a 2-flop synchronizer and a rising-edge detector: event pulse of 1 cycle, 3 cycles after the input edge.
REQ-016 FSM states: IDLE, ARM, FILL, RUN. ENABLE low forces IDLE from any state in the next cycle.
REQ-017 IDLE->ARM when ENABLE=1; ARM->FILL on wr_evt; FILL->RUN on wr_evt.
REQ-018 ARM wr_evt: start the writer on the current WR_BANK and pulse WR_LOAD; no frame completes.
REQ-019 FILL/RUN wr_evt: ready_bank<=WR_BANK, ready_valid<=1, WR_BANK<=3-RD_BANK-WR_BANK, WR_LOAD pulse.
REQ-020 wr_evt while ready_valid=1 overwrites the previous ready frame, which counts as a drop.
REQ-021 rd_evt in any non-IDLE state: if ready_valid, RD_BANK<=ready_bank, ready_valid<=0, RD_FRAME_VALID<=1; otherwise RD_BANK is kept. RD_LOAD pulses in both cases.
REQ-022 wr_evt and rd_evt in the same cycle: write update first, then the read takes the newly ready bank, leaving ready_valid=0.
REQ-023 Invariant: WR_BANK!=RD_BANK always.
REQ-024 WR_ADDR=BASE_ADDR+WR_BANK*FRAME_WORDS, WR_MAX_ADDR=WR_ADDR+FRAME_WORDS; the same rule applies to RD_ADDR/RD_MAX_ADDR. All four are registered and valid in the first cycle of the corresponding LOAD.
REQ-025 A LOAD rises 1 cycle after its event and stays high for LOAD_CYCLES cycles; a new event during a pulse restarts the count.
REQ-026 All arithmetic uses ADDR_W bits with no wrap. Elaboration fails if BASE_ADDR+3*FRAME_WORDS exceeds 2^ADDR_W.

Reset
REQ-027 Reset, and also entry to IDLE, sets: FSM=IDLE, WR_BANK=0, RD_BANK=1, ready_valid=0, RD_FRAME_VALID=0, LOADs=0, synchronizers=0.
REQ-028 Address outputs are reset to the bank 0 / bank 1 windows; there is no LOAD pulse on reset release.

Configuration
REQ-029 Macro FBS_STATS_EN defined: adds outputs DROP_CNT[15:0], which saturates at 16'hFFFF and increments on each REQ-020 event, and FRAME_CNT[15:0], which wraps and increments on each completed frame. Both are cleared on the IDLE->ARM transition.
REQ-030 FBS_STATS_EN undefined: these ports and their counters are absent; all other behaviour is identical.

Structure
REQ-031 Package fbs_pkg: state enum, 2-bit bank type, function third_bank(a,b)=3-a-b.
REQ-032 Sub-module fbs_evt_sync (synchronizer + edge detect) is instantiated twice.

Verification
REQ-033 Reset, ENABLE=1, two WR_VSYNC edges -> ARM->FILL->RUN; WR_BANK 0->0->2; ready_bank=0; WR_LOAD high 4 cycles each time, starting 4 cycles after the edge.
REQ-034 RUN, then RD_VSYNC -> RD_BANK=0, WR_ADDR=768000, RD_ADDR=0, RD_MAX_ADDR=384000, RD_FRAME_VALID=1.
REQ-035 Three WR edges with no RD edge -> WR_BANK cycles 0,2,0 and never equals RD_BANK=1; DROP_CNT=1 with FBS_STATS_EN.
REQ-036 WR and RD edges in the same cycle while ready_valid=1 -> RD_BANK=old WR_BANK, ready_valid=0, DROP_CNT+1.
REQ-037 ENABLE dropped mid-LOAD pulse -> next cycle IDLE, LOADs=0, banks 0/1; re-enable then requires ARM.
REQ-038 RESET_N asserted asynchronously mid-frame -> all outputs take REQ-027/028 values without a clock edge.
